cp0_regfile: RTL
================

// Module: cp0_regfile
// PURPOSE
//  Coprocessor-0 state for the single-cycle MIPS core: holds Status/Cause/EPC, selects the next PC.
//  Consumes the control unit's wsta/wcau/wepc/mtc0/mfc0/selpc/exc/cause strobes.
//  Produces Status (sta) and the synchronised interrupt request (intr) back to the control unit.
//  Sits beside the PC register: npc feeds the PC; c0_rdata feeds the register-file write port.
// PARAMETERS
//  EXC_BASE    32'h0000_0008  handler entry address loaded on exc
//  STATUS_RST  32'h0000_000F  Status value after reset (all four sources enabled)
//  CNT_W       8              width of saturating exception counter
// PORTS
//  Clk        in   1      single clock, all state updates on rising edge
//  Reset      in   1      synchronous, active-high
//  irq_in     in   1      raw external interrupt level from device (asynchronous)
//  intr       out  1      pending interrupt request to control unit
//  inta       in   1      interrupt acknowledge from control unit
//  exc        in   1      exception/interrupt taken this cycle
//  wsta       in   1      Status write enable
//  wcau       in   1      Cause write enable
//  wepc       in   1      EPC write enable
//  mtc0       in   1      mtc0 instruction executing
//  mfc0       in   2      read select: 00 wb_in, 01 Status, 10 Cause, 11 EPC
//  selpc      in   2      PC select: 00 pc_next, 01 EPC (eret), 10/11 EXC_BASE
//  cause_in   in   32     cause word, ExcCode in bits [3:2]
//  wdata      in   32     rt value for mtc0
//  pc         in   32     PC of current instruction
//  pc_next    in   32     normal next PC (pc+4/branch/jump)
//  wb_in      in   32     ALU/memory writeback value
//  c0_rdata   out  32     writeback value after mfc0 mux
//  npc        out  32     next PC
//  sta        out  32     current Status
//  exc_count  out  CNT_W  exceptions taken since reset, saturating
// BEHAVIOUR
//  Reset values: Status=STATUS_RST, Cause=0, EPC=0, exc_count=0, intr=0, sync flops=0.
//  Combinational outputs: c0_rdata, npc, sta. They reflect register values from before the edge.
//  npc: selpc 00 -> pc_next; 01 -> EPC; 10 or 11 -> EXC_BASE.
//  Status update priority per edge: exc > eret (wsta & selpc==01) > mtc0 to Status (wsta & ~exc & selpc!=01).
//   exc:   Status <= {Status[27:0],4'h0}, so nested sources are masked.
//   eret:  Status <= {4'h0,Status[31:4]}, restoring the previous mask.
//   mtc0:  Status <= wdata.
//  Cause: on exc, Cause <= cause_in; else if wcau, Cause <= wdata.
//  EPC on exc:
//   ExcCode 00 (interrupt) or 01 (syscall): EPC <= pc_next, resuming after the instruction.
//   ExcCode 10 or 11: EPC <= pc, the faulting instruction.
//  EPC when not exc: if wepc, EPC <= wdata.
//  Interrupt path: irq_in passes through two flops.
//   A rising edge on the synchronised level sets pending; intr = pending.
//   Latency from irq_in edge to intr high is 3 clocks.
//   inta clears pending at the next edge.
//   A new edge in the same cycle as inta leaves pending set (set wins).
//   Level held high does not re-trigger.
//  exc_count increments on each exc cycle and saturates at all-ones.
//  A Reset asserted mid-handler overrides every write in that cycle.
// STRUCTURE
//  Shared package cp0_pkg:
//   CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14
//   EXC_INT=2'b00, EXC_SYS=2'b01, EXC_UNI=2'b10, EXC_OVR=2'b11
//   SELPC_SEQ/EPC/EXC, MFC0_WB/STA/CAU/EPC
//  Sub-module irq_sync: 2-flop synchroniser, edge detect and pending latch; ports Clk, Reset, irq_in, inta, intr.
// TESTING
//  1. Reset, then idle: sta=32'hF, npc=pc_next, c0_rdata=wb_in, intr=0.
//  2. Syscall at pc=0x40, pc_next=0x44, exc=1, cause=0x4:
//     -> npc=0x8; after edge EPC=0x44, Cause=0x4, Status=0xF0.
//     Then eret (selpc=01, wsta=1) -> npc=0x44; after edge Status=0xF.
//  3. Overflow at pc=0x80 (cause=0xC) -> EPC=0x80.
//     Then mfc0=11 -> c0_rdata=0x80; mfc0=10 -> c0_rdata=0xC.
//  4. irq_in rises -> intr=1 on the 3rd edge.
//     inta pulse -> intr=0 next edge.
//     A re-rise of irq_in coincident with inta keeps intr=1.
//  5. mtc0 wdata=0x5 with wsta=1 -> Status=0x5.
//     Same cycle with exc=1 -> Status={old[27:0],0}, mtc0 ignored.
//  6. 300 back-to-back exc cycles -> exc_count=8'hFF; Reset -> all registers back to reset values.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared coprocessor-0 definitions: register numbers, exception codes and
// the encodings of the PC-select and mfc0 read-select fields.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_BASE_DEF   = 32'h0000_0008;
  localparam logic [31:0] STATUS_RST_DEF = 32'h0000_000F;
  localparam int          CNT_W_DEF      = 8;

  typedef enum logic [1:0] {
    EXC_INT = 2'b00,
    EXC_SYS = 2'b01,
    EXC_UNI = 2'b10,
    EXC_OVR = 2'b11
  } exc_code_e;

  typedef enum logic [1:0] {
    SELPC_SEQ = 2'b00,
    SELPC_EPC = 2'b01,
    SELPC_EXC = 2'b10
  } selpc_e;

  typedef enum logic [1:0] {
    MFC0_WB  = 2'b00,
    MFC0_STA = 2'b01,
    MFC0_CAU = 2'b10,
    MFC0_EPC = 2'b11
  } mfc0_e;

  // Interrupts and syscalls resume after the instruction; faults retry it.
  function automatic logic resumes_after(input exc_code_e code);
    return (code == EXC_INT) || (code == EXC_SYS);
  endfunction

endpackage

// File: rtl/cp0_regfile_irq_sync.sv
// Interrupt front end: two-flop synchroniser on the raw device level, rising
// edge detect on the synchronised level, and a pending latch cleared by inta.
module irq_sync
  import cp0_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic irq_in,
  input  logic inta,
  output logic intr
);

  logic sync1;
  logic sync2;
  logic sync_prev;
  logic pending;
  logic rise;

  assign rise = sync2 & ~sync_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes the
  // synchroniser chain shift by exactly one stage per clock.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      pending   <= 1'b0;
    end else begin
      sync1     <= irq_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      // A fresh edge beats a simultaneous acknowledge so it is never lost.
      if (rise)
        pending <= 1'b1;
      else if (inta)
        pending <= 1'b0;
    end
  end

  assign intr = pending;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC, exception counter,
// next-PC select and the mfc0 writeback mux for the single-cycle core.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_BASE   = EXC_BASE_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             irq_in,
  output logic             intr,
  input  logic             inta,
  input  logic             exc,
  input  logic             wsta,
  input  logic             wcau,
  input  logic             wepc,
  input  logic             mtc0,
  input  logic [1:0]       mfc0,
  input  logic [1:0]       selpc,
  input  logic [31:0]      cause_in,
  input  logic [31:0]      wdata,
  input  logic [31:0]      pc,
  input  logic [31:0]      pc_next,
  input  logic [31:0]      wb_in,
  output logic [31:0]      c0_rdata,
  output logic [31:0]      npc,
  output logic [31:0]      sta,
  output logic [CNT_W-1:0] exc_count
);

  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        eret;
  exc_code_e   exc_code;

  // mtc0 is already decoded into wsta/wcau/wepc by the control unit.
  logic unused_mtc0;
  assign unused_mtc0 = mtc0;

  assign eret     = wsta && (selpc == SELPC_EPC);
  assign exc_code = exc_code_e'(cause_in[3:2]);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status    <= STATUS_RST;
      cause     <= '0;
      epc       <= '0;
      exc_count <= '0;
    end else begin
      // Status acts as a 4-bit mask stack: exc pushes, eret pops.
      if (exc)
        status <= {status[27:0], 4'h0};
      else if (eret)
        status <= {4'h0, status[31:4]};
      else if (wsta)
        status <= wdata;

      if (exc)
        cause <= cause_in;
      else if (wcau)
        cause <= wdata;

      if (exc)
        epc <= resumes_after(exc_code) ? pc_next : pc;
      else if (wepc)
        epc <= wdata;

      if (exc && (exc_count != '1))
        exc_count <= exc_count + 1'b1;
    end
  end

  // NOTE: every output of a combinational block gets a default before the
  // case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    npc = pc_next;
    case (selpc)
      SELPC_SEQ: npc = pc_next;
      SELPC_EPC: npc = epc;
      default:   npc = EXC_BASE;
    endcase
  end

  always_comb begin
    c0_rdata = wb_in;
    case (mfc0)
      MFC0_WB:  c0_rdata = wb_in;
      MFC0_STA: c0_rdata = status;
      MFC0_CAU: c0_rdata = cause;
      MFC0_EPC: c0_rdata = epc;
      default:  c0_rdata = wb_in;
    endcase
  end

  assign sta = status;

  irq_sync u_irq_sync (
    .Clk    (Clk),
    .Reset  (Reset),
    .irq_in (irq_in),
    .inta   (inta),
    .intr   (intr)
  );

endmodule
